// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Function : Byte-stream program loader for the MIPS instruction memory.
//             - Accepts bytes over a valid/ready handshake.
//             - Packs them into big-endian 32-bit words.
//             - The first word is the word count N.
//             - The next N words are written to instruction memory from
//               address 0.
//             - A trailing XOR checksum word is then verified.
//             - The CPU is held in reset until a load completes cleanly.
//  Revision : 1.0  initial release
// ============================================================================
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int CW          = $clog2(DEPTH_WORDS + 1)
) (
  input  logic          clk,
  input  logic          reset,        // asynchronous, active-low
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          instwen,
  output logic [31:0]   instrdatain,
  output logic [31:0]   addwrite,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] words_loaded
);

  // Load sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  // Largest legal count, widened so the full 32-bit count word is compared
  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);
  // Zero padding above the word index inside the byte address
  localparam int          AW_PAD  = 32 - CW - 2;

  // Registered state
  logic [2:0]    state_q,       state_d;
  logic [1:0]    byte_cnt_q,    byte_cnt_d;
  logic [23:0]   word_buf_q,    word_buf_d;     // first three bytes of a word
  logic [CW-1:0] n_q,           n_d;            // latched word count
  logic [31:0]   csum_q,        csum_d;         // running XOR of data words
  logic [CW-1:0] words_q,       words_d;        // data words written so far
  logic          instwen_q,     instwen_d;
  logic [31:0]   instrdatain_q, instrdatain_d;
  logic [31:0]   addwrite_q,    addwrite_d;

  // Combinational helpers
  logic          w_active;      // a load is in progress and bytes are taken
  logic          w_accept;      // a byte is transferred this cycle
  logic          w_word_done;   // this byte completes a 32-bit word
  logic [31:0]   w_word;        // the completed word (valid with w_word_done)
  logic [CW-1:0] w_words_inc;

  assign w_active    = (state_q == ST_COUNT) || (state_q == ST_DATA) ||
                       (state_q == ST_CHECK);
  assign w_accept    = in_valid && w_active;
  assign w_word_done = w_accept && (byte_cnt_q == 2'd3);
  assign w_word      = {word_buf_q, in_data};
  assign w_words_inc = words_q + CW'(1);

  // Next-state logic: byte assembly, sequencing, memory-write generation
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    word_buf_d    = word_buf_q;
    n_d           = n_q;
    csum_d        = csum_q;
    words_d       = words_q;
    instwen_d     = 1'b0;            // write strobe is a single-cycle pulse
    instrdatain_d = instrdatain_q;   // data/address hold until the next write
    addwrite_d    = addwrite_q;

    // Bytes shift in from the right, so the first byte of a word ends up
    // in the most significant lane when the fourth byte arrives.
    if (w_accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      word_buf_d = {word_buf_q[15:0], in_data};
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_COUNT;
          byte_cnt_d = 2'd0;
          words_d    = '0;
          csum_d     = '0;
        end
      end

      ST_COUNT: begin
        if (w_word_done) begin
          if ((w_word == 32'd0) || (w_word > DEPTH_W)) begin
            state_d = ST_ERR;
          end else begin
            n_d     = w_word[CW-1:0];
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (w_word_done) begin
          instwen_d     = 1'b1;
          instrdatain_d = w_word;
          addwrite_d    = {{AW_PAD{1'b0}}, words_q, 2'b00};
          csum_d        = csum_q ^ w_word;
          words_d       = w_words_inc;
          if (w_words_inc == n_q) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        // The checksum word is compared only and never written to memory
        if (w_word_done) begin
          state_d = (w_word == csum_q) ? ST_DONE : ST_ERR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any load in progress and drops the partial word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= 2'd0;
      word_buf_q    <= '0;
      n_q           <= '0;
      csum_q        <= '0;
      words_q       <= '0;
      instwen_q     <= 1'b0;
      instrdatain_q <= '0;
      addwrite_q    <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      word_buf_q    <= word_buf_d;
      n_q           <= n_d;
      csum_q        <= csum_d;
      words_q       <= words_d;
      instwen_q     <= instwen_d;
      instrdatain_q <= instrdatain_d;
      addwrite_q    <= addwrite_d;
    end
  end

  // Status outputs decode directly from the registered state. The CPU is
  // released only after a clean load.
  assign in_ready     = w_active;
  assign busy         = w_active;
  assign done         = (state_q == ST_DONE);
  assign err          = (state_q == ST_ERR);
  assign cpu_reset    = (state_q != ST_DONE);
  assign instwen      = instwen_q;
  assign instrdatain  = instrdatain_q;
  assign addwrite     = addwrite_q;
  assign words_loaded = words_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Function : Self-checking bench for imem_loader.
//             - Table of complete load scenarios.
//             - Hand-written sequences for reset-abort, start-while-busy,
//               restart and the full-depth load.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;

  localparam int DEPTH_WORDS = 256;
  localparam int CW          = $clog2(DEPTH_WORDS + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          instwen;
  logic [31:0]   instrdatain;
  logic [31:0]   addwrite;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] words_loaded;

  imem_loader #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .instwen      (instwen),
    .instrdatain  (instrdatain),
    .addwrite     (addwrite),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Write monitor: records every memory write strobe
  int          wr_n = 0;
  logic [31:0] wr_addr [0:511];
  logic [31:0] wr_data [0:511];

  always @(negedge clk) begin
    if (instwen === 1'b1) begin
      if (wr_n < 512) begin
        wr_addr[wr_n] = addwrite;
        wr_data[wr_n] = instrdatain;
      end
      wr_n = wr_n + 1;
    end
  end

  typedef struct {
    logic [31:0]      n;           // count word sent
    int               nwords;      // data words sent
    logic [3:0][31:0] words;
    logic [31:0]      csum;
    bit               send_csum;
    bit               gaps;
    bit               exp_done;    // otherwise ERR expected
    int               exp_wl;
    int               exp_writes;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int gap;
    int bound;
    if (gaps) begin
      gap = $urandom_range(0, 2);
      in_valid = 1'b0;
      repeat (gap) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    bound    = 0;
    while (in_ready !== 1'b1 && bound < 50) begin
      tick();
      bound++;
    end
    if (bound >= 50) begin
      n_checks++;
      $display("FAIL byte_timeout: in_ready got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    send_byte(w[31:24], gaps);
    send_byte(w[23:16], gaps);
    send_byte(w[15:8],  gaps);
    send_byte(w[7:0],   gaps);
  endtask

  task automatic run_load(input vec_t v);
    int base;
    base = wr_n;
    pulse_start();
    check("start_in_ready",  in_ready,     1);
    check("start_busy",      busy,         1);
    check("start_cpu_reset", cpu_reset,    1);
    check("start_done",      done,         0);
    check("start_err",       err,          0);
    check("start_wl",        words_loaded, 0);
    send_word(v.n, v.gaps);
    for (int k = 0; k < v.nwords; k++) begin
      send_word(v.words[k], v.gaps);
      check("wr_instwen",  instwen,     1);
      check("wr_addr",     addwrite,    32'(4 * k));
      check("wr_data",     instrdatain, v.words[k]);
      check("wr_in_ready", in_ready,    1);
    end
    if (v.send_csum) send_word(v.csum, v.gaps);
    check("end_done",      done,         v.exp_done);
    check("end_err",       err,          !v.exp_done);
    check("end_cpu_reset", cpu_reset,    !v.exp_done);
    check("end_busy",      busy,         0);
    check("end_in_ready",  in_ready,     0);
    check("end_wl",        words_loaded, v.exp_wl);
    tick();
    check("end_writes", wr_n - base, v.exp_writes);
    for (int k = 0; k < v.exp_writes && k < v.nwords; k++) begin
      check("mon_addr", wr_addr[base + k], 32'(4 * k));
      check("mon_data", wr_data[base + k], v.words[k]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;

    // Scenario table: count, data, checksum, expected outcome
    vecs[0] = '{n: 32'd2, nwords: 2,
                words: {32'h0, 32'h0, 32'h20090003, 32'h20080005},
                csum: 32'h00010006, send_csum: 1, gaps: 0,
                exp_done: 1, exp_wl: 2, exp_writes: 2};
    vecs[1] = '{n: 32'd2, nwords: 2,
                words: {32'h0, 32'h0, 32'h20090003, 32'h20080005},
                csum: 32'h00010007, send_csum: 1, gaps: 0,
                exp_done: 0, exp_wl: 2, exp_writes: 2};
    vecs[2] = '{n: 32'd0, nwords: 0, words: '0, csum: 32'h0,
                send_csum: 0, gaps: 0, exp_done: 0, exp_wl: 0,
                exp_writes: 0};
    vecs[3] = '{n: 32'd257, nwords: 0, words: '0, csum: 32'h0,
                send_csum: 0, gaps: 0, exp_done: 0, exp_wl: 0,
                exp_writes: 0};
    vecs[4] = '{n: 32'd2, nwords: 2,
                words: {32'h0, 32'h0, 32'h20090003, 32'h20080005},
                csum: 32'h00010006, send_csum: 1, gaps: 1,
                exp_done: 1, exp_wl: 2, exp_writes: 2};
    vecs[5] = '{n: 32'd3, nwords: 3,
                words: {32'h0, 32'h00000004, 32'h00000002, 32'h00000001},
                csum: 32'h00000007, send_csum: 1, gaps: 1,
                exp_done: 1, exp_wl: 3, exp_writes: 3};

    // Reset values
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    check("rst_in_ready",  in_ready,     0);
    check("rst_instwen",   instwen,      0);
    check("rst_data",      instrdatain,  0);
    check("rst_addr",      addwrite,     0);
    check("rst_cpu_reset", cpu_reset,    1);
    check("rst_busy",      busy,         0);
    check("rst_done",      done,         0);
    check("rst_err",       err,          0);
    check("rst_wl",        words_loaded, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_load(vecs[i]);

    // Reset mid-load: count word plus one data byte, then reset
    pulse_start();
    send_word(32'd3, 0);
    send_byte(8'h11, 0);
    base     = wr_n;
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h22;
    tick();
    check("mid_rst_in_ready",  in_ready,     0);
    check("mid_rst_instwen",   instwen,      0);
    check("mid_rst_data",      instrdatain,  0);
    check("mid_rst_addr",      addwrite,     0);
    check("mid_rst_cpu_reset", cpu_reset,    1);
    check("mid_rst_busy",      busy,         0);
    check("mid_rst_done",      done,         0);
    check("mid_rst_err",       err,          0);
    check("mid_rst_wl",        words_loaded, 0);
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    check("mid_rst_no_writes", wr_n - base, 0);
    run_load(vecs[0]);

    // start during DATA is ignored
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h20080005, 0);
    pulse_start();
    check("ign_start_busy", busy,         1);
    check("ign_start_wl",   words_loaded, 1);
    send_word(32'h20090003, 0);
    check("ign_start_instwen", instwen,  1);
    check("ign_start_addr",    addwrite, 32'h4);
    send_word(32'h00010006, 0);
    check("ign_start_done", done,         1);
    check("ign_start_wl2",  words_loaded, 2);

    // Restart from DONE reasserts cpu_reset and overwrites from address 0
    pulse_start();
    check("restart_cpu_reset", cpu_reset, 1);
    check("restart_done",      done,      0);
    send_word(32'd1, 0);
    send_word(32'hDEADBEEF, 0);
    check("restart_instwen", instwen,     1);
    check("restart_addr",    addwrite,    32'h0);
    check("restart_data",    instrdatain, 32'hDEADBEEF);
    send_word(32'hDEADBEEF, 0);
    check("restart_end_done", done, 1);

    // Full-depth load: words 0..255 XOR to zero
    base = wr_n;
    pulse_start();
    send_word(32'd256, 0);
    for (int k = 0; k < 256; k++) send_word(32'(k), 0);
    check("full_last_addr", addwrite,     32'h3FC);
    check("full_last_data", instrdatain,  32'hFF);
    check("full_wl",        words_loaded, 256);
    send_word(32'h0, 0);
    check("full_done",      done,         1);
    check("full_writes",    wr_n - base,  256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Program loader that sits directly upstream of the MIPS top's instruction-memory write port. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and drives `instwen`/`instrdatain`/`addwrite` to fill instruction memory from address 0. It verifies a trailing XOR checksum and holds the CPU in reset until a load completes cleanly.

## Interface
Parameters:
- DEPTH_WORDS, 256, maximum instruction words accepted; a count above this is an error.
- CW, $clog2(DEPTH_WORDS+1), width of word counters.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start  input  1  one-cycle request to begin a load.
- in_valid  input  1  byte stream valid.
- in_data  input  8  byte stream data.
- in_ready  output  1  loader can accept a byte.
- instwen  output  1  instruction-memory write enable (to top `instwen`).
- instrdatain  output  32  word to write (to top `instrdatain`).
- addwrite  output  32  byte address of the write (to top `addwrite`).
- cpu_reset  output  1  active-high hold for the CPU's `reset`.
- busy  output  1  load in progress.
- done  output  1  last load succeeded.
- err  output  1  last load failed.
- words_loaded  output  CW  data words written in the current/last load.

## Operation
- States: IDLE, COUNT, DATA, CHECK, DONE, ERR.
- Byte accepted when in_valid && in_ready. in_ready = 1 only in COUNT, DATA, CHECK.
- Word assembly: a 2-bit byte counter; first byte of each word goes to [31:24], last to [7:0]. Counter wraps 3->0 on each completed word.
- IDLE/DONE/ERR + start -> COUNT; clear words_loaded, checksum accumulator, done, err; busy=1, cpu_reset=1.
- COUNT: first word = N. N==0 or N>DEPTH_WORDS -> ERR. Otherwise latch N -> DATA.
- DATA: each completed word k (0-based) is written: instrdatain=word, addwrite=4*k, instwen=1 for one cycle; checksum ^= word; words_loaded=k+1. After word N-1 -> CHECK.
- CHECK: completed word compared with checksum; equal -> DONE, else ERR. Not written to memory.
- DONE: done=1, busy=0, cpu_reset=0.
- ERR: err=1, busy=0, cpu_reset=1.
- start while in COUNT/DATA/CHECK is ignored.
- addwrite upper bits beyond 4*(DEPTH_WORDS-1) are always 0.

## Timing
- Reset values: in_ready=0, instwen=0, instrdatain=0, addwrite=0, cpu_reset=1, busy=0, done=0, err=0, words_loaded=0; state IDLE; byte counter 0.
- Reset asserted mid-load aborts immediately: all outputs to reset values, partial word discarded, no further instwen.
- start -> COUNT and in_ready=1 on the next cycle.
- instwen is registered: asserted the cycle after the 4th byte of a data word is accepted, for exactly one cycle; instrdatain/addwrite valid in that same cycle and held until the next write.
- in_ready stays 1 during the instwen cycle (no backpressure; back-to-back bytes at full rate supported, minimum 4 cycles per word).
- Gaps in in_valid stall assembly only; no timeout.
- DONE/ERR (and done/err, cpu_reset change) take effect the cycle after the last checksum byte or the bad count word is accepted; in_ready=0 from that cycle.
- Restart from DONE reasserts cpu_reset the cycle after start.

## Test plan
- Good load: start; bytes for N=2, words 0x20080005, 0x20090003, checksum 0x00010006 -> instwen at addwrite 0x0 data 0x20080005, at 0x4 data 0x20090003; done=1, err=0, cpu_reset=0, words_loaded=2.
- Bad checksum: same load with checksum 0x00010007 -> two writes occur, then err=1, done=0, cpu_reset=1.
- Illegal count: N=0, and N=DEPTH_WORDS+1 -> ERR after count word, zero instwen pulses, in_ready=0.
- Stream gaps: good load with in_valid toggled pseudo-randomly -> identical writes, addresses and final done=1.
- Reset mid-load: assert reset after 5 bytes of N=3 load -> all outputs at reset values next cycle, no further instwen; subsequent full load succeeds from address 0.
- start during DATA ignored (no restart, words_loaded continues); start from DONE -> cpu_reset=1, second load overwrites from address 0.
